// File: rtl/udp_pkg.sv
// udp_pkg: shared UDP constants, header beat indices, tx FSM state type and
// the byte-swap helper that puts a 16-bit field onto the wire MSB first.
package udp_pkg;

    localparam int unsigned UDP_HEAD_N     = 8;
    localparam int unsigned UDP_HEAD_BEATS = 4;
    // Largest payload whose UDP length (payload + header) still fits 16 bits
    localparam int unsigned UDP_MAX_PLD    = 65535 - UDP_HEAD_N;

    localparam logic [15:0] UDP_DEF_SRC_PORT = 16'd18070;
    localparam logic [15:0] UDP_DEF_DST_PORT = 16'd18070;

    // Header beat indices, in wire order
    localparam logic [1:0] HD_SRC  = 2'd0;
    localparam logic [1:0] HD_DST  = 2'd1;
    localparam logic [1:0] HD_LEN  = 2'd2;
    localparam logic [1:0] HD_CSUM = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_HEAD = 3'b010,
        S_DATA = 3'b100
    } tx_state_e;

    // First wire byte lives in [7:0], so the field MSB goes there
    function automatic logic [15:0] swap16(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

endpackage

// File: rtl/udp_tx_head.sv
// udp_tx_head: selects the 16-bit UDP header beat for the current beat index.
// Ports:
//   i_hd       header beat index 0..3
//   i_udp_len  UDP length (payload + 8)
//   o_data_c   header beat, wire order (combinational)
module udp_tx_head
    import udp_pkg::*;
#(
    parameter int unsigned       PORT_W   = 16,
    parameter logic [PORT_W-1:0] SRC_PORT = UDP_DEF_SRC_PORT,
    parameter logic [PORT_W-1:0] DST_PORT = UDP_DEF_DST_PORT,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic [1:0]       i_hd,
    input  logic [CNT_W-1:0] i_udp_len,
    output logic [15:0]      o_data_c
);

    // Checksum beat is always zero (checksum disabled for IPv4)
    always_comb begin
        o_data_c = 16'h0000;
        unique case (i_hd)
            HD_SRC:  o_data_c = swap16(16'(SRC_PORT));
            HD_DST:  o_data_c = swap16(16'(DST_PORT));
            HD_LEN:  o_data_c = swap16(16'(i_udp_len));
            HD_CSUM: o_data_c = 16'h0000;
            default: o_data_c = 16'h0000;
        endcase
    end

endmodule

// File: rtl/udp_tx.sv
// udp_tx: prepends the 8-byte UDP header (4 beats) to an application payload
// stream and forwards header + payload to IPv4 tx. Payload is a zero-latency
// pass-through; header beats come from registered state.
// Ports:
//   clk, nreset            clock, synchronous active-low reset
//   cancel_i / cancel_o    app abort, forwarded while a datagram is open
//   valid_i/ready_o        app side handshake; start_i/term_i frame markers
//   data_i, len_i          payload beat and its valid byte count
//   pld_len_i              payload byte count, sampled with start_i
//   valid_o/ready_i        IP tx handshake; start_o/term_o frame markers
//   data_o, len_o          header/payload beat and byte count
//   udp_len_o              UDP length field (payload + 8)
//   len_err_o              one-cycle pulse on length mismatch/overflow
module udp_tx
    import udp_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       LEN_W    = 2,
    parameter int unsigned       PORT_W   = 16,
    parameter logic [PORT_W-1:0] SRC_PORT = UDP_DEF_SRC_PORT,
    parameter logic [PORT_W-1:0] DST_PORT = UDP_DEF_DST_PORT,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cancel_i,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic              term_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [CNT_W-1:0]  pld_len_i,
    output logic              ready_o,
    input  logic              ready_i,
    output logic              valid_o,
    output logic              start_o,
    output logic              term_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic [CNT_W-1:0]  udp_len_o,
    output logic              cancel_o,
    output logic              len_err_o
);

    tx_state_e        r_state, w_state_nxt;
    logic [1:0]       r_hd, w_hd_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_udp_len, w_udp_len_nxt;
    logic             r_len_err, w_len_err_nxt;
    logic [15:0]      w_head_data;
    logic             w_acc;
    logic [CNT_W-1:0] w_cnt_sum;

    udp_tx_head #(
        .PORT_W   (PORT_W),
        .SRC_PORT (SRC_PORT),
        .DST_PORT (DST_PORT),
        .CNT_W    (CNT_W)
    ) u_head (
        .i_hd      (r_hd),
        .i_udp_len (r_udp_len),
        .o_data_c  (w_head_data)
    );

    assign w_acc     = valid_i & ready_i;
    assign w_cnt_sum = r_cnt + CNT_W'(len_i);

    // State register
    always_ff @(posedge clk) begin
        if (!nreset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Header index, payload count, latched length and error pulse
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_hd      <= 2'd0;
            r_cnt     <= '0;
            r_udp_len <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_hd      <= w_hd_nxt;
            r_cnt     <= w_cnt_nxt;
            r_udp_len <= w_udp_len_nxt;
            r_len_err <= w_len_err_nxt;
        end
    end

    // Next state and outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_hd_nxt      = r_hd;
        w_cnt_nxt     = r_cnt;
        w_udp_len_nxt = r_udp_len;
        w_len_err_nxt = 1'b0;
        ready_o       = 1'b0;
        valid_o       = 1'b0;
        start_o       = 1'b0;
        term_o        = 1'b0;
        data_o        = '0;
        len_o         = '0;
        cancel_o      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // Start beat is left pending; it is consumed later in DATA
                if (valid_i && start_i) begin
                    w_state_nxt   = S_HEAD;
                    w_hd_nxt      = HD_SRC;
                    w_cnt_nxt     = '0;
                    w_udp_len_nxt = pld_len_i + CNT_W'(UDP_HEAD_N);
                    w_len_err_nxt = (pld_len_i == '0) ||
                                    (pld_len_i > CNT_W'(UDP_MAX_PLD));
                end
            end
            S_HEAD: begin
                valid_o = 1'b1;
                len_o   = LEN_W'(2);
                data_o  = DATA_W'(w_head_data);
                start_o = (r_hd == HD_SRC);
                if (ready_i) begin
                    if (r_hd == HD_CSUM) w_state_nxt = S_DATA;
                    else                 w_hd_nxt    = r_hd + 2'd1;
                end
                if (cancel_i) begin
                    cancel_o    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                valid_o = valid_i;
                ready_o = ready_i;
                data_o  = data_i;
                len_o   = len_i;
                term_o  = valid_i & term_i & ~cancel_i;
                // Cancel beats a same-cycle term: no term_o, no length check
                if (cancel_i) begin
                    cancel_o    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_acc) begin
                    w_cnt_nxt = w_cnt_sum;
                    if (term_i) begin
                        w_state_nxt   = S_IDLE;
                        w_len_err_nxt = (w_cnt_sum != (r_udp_len - CNT_W'(UDP_HEAD_N)));
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign udp_len_o = r_udp_len;
    assign len_err_o = r_len_err;

endmodule

// File: tb/tb_udp_tx.sv
// tb_udp_tx: directed datagrams against a queue model of the expected
// IP-side beat stream (header computed from ports and length arithmetic).
module tb_udp_tx;

    localparam int SRC = 18070;
    localparam int DST = 18070;

    logic        clk = 1'b0;
    logic        nreset, cancel_i, valid_i, start_i, term_i, ready_i;
    logic [15:0] data_i, pld_len_i;
    logic [1:0]  len_i;
    logic        ready_o, valid_o, start_o, term_o, cancel_o, len_err_o;
    logic [15:0] data_o, udp_len_o;
    logic [1:0]  len_o;

    always #5 clk = ~clk;

    udp_tx dut (
        .clk       (clk),
        .nreset    (nreset),
        .cancel_i  (cancel_i),
        .valid_i   (valid_i),
        .start_i   (start_i),
        .term_i    (term_i),
        .data_i    (data_i),
        .len_i     (len_i),
        .pld_len_i (pld_len_i),
        .ready_o   (ready_o),
        .ready_i   (ready_i),
        .valid_o   (valid_o),
        .start_o   (start_o),
        .term_o    (term_o),
        .data_o    (data_o),
        .len_o     (len_o),
        .udp_len_o (udp_len_o),
        .cancel_o  (cancel_o),
        .len_err_o (len_err_o)
    );

    typedef struct {
        logic [15:0] d;
        logic [1:0]  l;
        logic        s;
        logic        t;
        logic        h;
        int          hi;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       cb;
    logic [15:0] exp_udp_len;
    logic [15:0] hdr_seen[4];
    int          checks = 0;
    int          errors = 0;
    int          err_pulses = 0;
    int          first_wait = 0;
    int          rdy_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sw(input int v);
        return 16'(((v % 256) * 256) + ((v / 256) % 256));
    endfunction

    function automatic int bv(input int k);
        return (k * 37 + 5) % 256;
    endfunction

    function automatic logic [15:0] pay(input int i);
        return 16'(bv(2 * i) + bv(2 * i + 1) * 256);
    endfunction

    // Expected IP-side stream for one datagram
    task automatic push_dgram(input int pld, input int nbytes);
        beat_t b;
        int    len;
        int    nb;
        len = (pld + 8) % 65536;
        exp_udp_len = 16'(len);
        for (int k = 0; k < 4; k++) begin
            b.d  = (k == 0) ? sw(SRC) : (k == 1) ? sw(DST) : (k == 2) ? sw(len) : 16'h0000;
            b.l  = 2'd2;
            b.s  = (k == 0);
            b.t  = 1'b0;
            b.h  = 1'b1;
            b.hi = k;
            exp_q.push_back(b);
        end
        nb = (nbytes + 1) / 2;
        for (int i = 0; i < nb; i++) begin
            b.d  = pay(i);
            b.l  = (i == nb - 1 && (nbytes % 2) == 1) ? 2'd1 : 2'd2;
            b.s  = 1'b0;
            b.t  = (i == nb - 1);
            b.h  = 1'b0;
            b.hi = 0;
            exp_q.push_back(b);
        end
    endtask

    // App-side driver; also checks IDLE latency and both len_err windows
    task automatic drive(input int pld, input int nbytes);
        int nb;
        int n;
        logic head_err;
        logic term_err;
        nb       = (nbytes + 1) / 2;
        head_err = (pld == 0) || (pld > 65527);
        term_err = (nbytes != pld);
        for (int i = 0; i < nb; i++) begin
            @(posedge clk); #1;
            valid_i   = 1'b1;
            start_i   = (i == 0);
            term_i    = (i == nb - 1);
            data_i    = pay(i);
            len_i     = (i == nb - 1 && (nbytes % 2) == 1) ? 2'd1 : 2'd2;
            pld_len_i = 16'(pld);
            n = 0;
            forever begin
                @(negedge clk);
                n++;
                if (i == 0 && n == 1) chk("idle_no_valid", {31'd0, valid_o}, 32'd0);
                if (i == 0 && n == 2) chk("head_len_err", {31'd0, len_err_o}, {31'd0, head_err});
                if (ready_o) break;
                if (n > 300) begin
                    errors++;
                    $display("FAIL accept_timeout: beat %0d not accepted within 300 cycles", i);
                    break;
                end
            end
            if (i == 0) first_wait = n;
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        start_i = 1'b0;
        term_i  = 1'b0;
        @(negedge clk);
        chk("term_len_err", {31'd0, len_err_o}, {31'd0, term_err});
        @(negedge clk);
        chk("len_err_one_cycle", {31'd0, len_err_o}, 32'd0);
    endtask

    task automatic send(input int pld, input int nbytes);
        push_dgram(pld, nbytes);
        drive(pld, nbytes);
    endtask

    // IP-side ready: steady high or toggling every cycle
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) ready_i = 1'b1;
        else               ready_i = ~ready_i;
    end

    // Compare every presented beat against the head of the expected stream
    always @(negedge clk) begin
        if (nreset === 1'b1) begin
            if (len_err_o) err_pulses++;
            if (ready_o) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].h) begin
                    errors++;
                    $display("FAIL ready_early: ready_o high while header pending or no datagram");
                end
            end
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: data_o %0h with empty model", data_o);
                end else begin
                    cb = exp_q[0];
                    chk("data_o", {16'd0, data_o}, {16'd0, cb.d});
                    chk("len_o", {30'd0, len_o}, {30'd0, cb.l});
                    chk("start_o", {31'd0, start_o}, {31'd0, cb.s});
                    chk("term_o", {31'd0, term_o}, {31'd0, cb.t});
                    chk("udp_len_o", {16'd0, udp_len_o}, {16'd0, exp_udp_len});
                    if (ready_i) begin
                        if (cb.h) hdr_seen[cb.hi] = data_o;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        nreset = 1'b0; cancel_i = 1'b0; valid_i = 1'b0; start_i = 1'b0;
        term_i = 1'b0; data_i = 16'h0; len_i = 2'd0; pld_len_i = 16'h0; ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_flags", {28'd0, start_o, term_o, cancel_o, len_err_o}, 32'd0);
        chk("rst_data", {16'd0, data_o}, 32'd0);
        chk("rst_len", {30'd0, len_o}, 32'd0);
        chk("rst_udp_len", {16'd0, udp_len_o}, 32'd0);
        @(posedge clk); #1;
        nreset = 1'b1;

        // cancel while idle is ignored
        cancel_i = 1'b1;
        @(negedge clk);
        chk("idle_cancel_o", {31'd0, cancel_o}, 32'd0);
        @(posedge clk); #1;
        cancel_i = 1'b0;
        @(negedge clk);
        chk("idle_cancel_valid", {31'd0, valid_o}, 32'd0);

        // 6-byte payload: literal header and N+5 first accept (6th negedge)
        send(6, 6);
        chk("hd0_lit", {16'd0, hdr_seen[0]}, 32'h9646);
        chk("hd1_lit", {16'd0, hdr_seen[1]}, 32'h9646);
        chk("hd2_lit", {16'd0, hdr_seen[2]}, 32'h0E00);
        chk("hd3_lit", {16'd0, hdr_seen[3]}, 32'h0000);
        chk("first_accept_latency", 32'(first_wait), 32'd6);

        // odd payload, last beat of 1 byte
        send(5, 5);
        chk("len5_lit", {16'd0, hdr_seen[2]}, 32'h0D00);

        // toggling ready stalls header and payload
        rdy_mode = 1;
        send(10, 10);
        rdy_mode = 0;
        chk("toggle_len_lit", {16'd0, hdr_seen[2]}, 32'h1200);
        chk("toggle_src_lit", {16'd0, hdr_seen[0]}, 32'h9646);

        // short payload: one len_err pulse after term
        send(6, 4);

        // cancel during header beat 2
        push_dgram(6, 6);
        @(posedge clk); #1;
        valid_i = 1'b1; start_i = 1'b1; term_i = 1'b0;
        data_i = pay(0); len_i = 2'd2; pld_len_i = 16'd6;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        cancel_i = 1'b1;
        @(negedge clk);
        chk("cancel_o_same", {31'd0, cancel_o}, 32'd1);
        chk("cancel_at_hd2", {16'd0, data_o}, 32'h0E00);
        @(posedge clk); #1;
        cancel_i = 1'b0; valid_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        chk("cancel_valid_off", {31'd0, valid_o}, 32'd0);
        chk("cancel_o_off", {31'd0, cancel_o}, 32'd0);
        chk("cancel_no_err", {31'd0, len_err_o}, 32'd0);
        exp_q.delete();
        send(6, 6);

        // oversize payload: wrapped length and head error, mismatched term
        send(65530, 4);
        chk("wrap_len_lit", {16'd0, hdr_seen[2]}, 32'h0200);

        // reset mid-header
        push_dgram(6, 6);
        @(posedge clk); #1;
        valid_i = 1'b1; start_i = 1'b1; term_i = 1'b0;
        data_i = pay(0); len_i = 2'd2; pld_len_i = 16'd6;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        nreset = 1'b0; valid_i = 1'b0; start_i = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1;
        @(negedge clk);
        chk("midrst_valid", {31'd0, valid_o}, 32'd0);
        chk("midrst_udp_len", {16'd0, udp_len_o}, 32'd0);
        exp_q.delete();
        send(2, 2);

        chk("err_pulses", 32'(err_pulses), 32'd3);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_tx.md
# udp_tx

Prepends an 8-byte UDP header to an application payload stream and forwards header plus payload to the IPv4 transmit layer. Sits between the application and the IP tx block, mirroring the UDP receive path. Checksum is transmitted as 0x0000 (legal for IPv4). Supports DATA_W = 16 only.

## Interface
- DATA_W, 16: datapath width; only 16 supported
- LEN_W, 2: byte-count width per beat; value 1 or 2 valid bytes
- PORT_W, 16: port field width
- SRC_PORT, 16'd18070: source port inserted in header
- DST_PORT, 16'd18070: destination port inserted in header
- CNT_W, 16: payload/UDP length width

- clk  in  1  clock; single clock domain
- nreset  in  1  synchronous, active-low reset
- cancel_i  in  1  app aborts current datagram
- valid_i  in  1  app beat valid
- start_i  in  1  first payload beat of datagram
- term_i  in  1  last payload beat
- data_i  in  DATA_W  payload; first wire byte in [7:0]
- len_i  in  LEN_W  valid bytes in beat (2 except on term beat)
- pld_len_i  in  CNT_W  payload byte count; sampled with start_i
- ready_o  out  1  app beat accepted when valid_i & ready_o
- ready_i  in  1  IP tx accepts beat
- valid_o  out  1  beat valid to IP tx
- start_o  out  1  first UDP header beat
- term_o  out  1  last beat of datagram
- data_o  out  DATA_W  header/payload beat
- len_o  out  LEN_W  valid bytes in beat
- udp_len_o  out  CNT_W  pld_len+8, stable from start_o until term accepted
- cancel_o  out  1  abort forwarded to IP tx
- len_err_o  out  1  one-cycle pulse on payload length mismatch or overflow

## Operation
- FSM, one-hot: IDLE, HEAD, DATA. Header beat counter hd_q 0..3.
- IDLE: ready_o=0, valid_o=0, data_o=0. valid_i & start_i -> latch udp_len_q = pld_len_i+8 (mod 2^16), hd_q=0, go HEAD. Start beat is NOT consumed in IDLE.
- HEAD: ready_o=0, valid_o=1, len_o=2. Beats, MSB on [7:0]: hd 0 {SRC_PORT[7:0],SRC_PORT[15:8]} with start_o=1; hd 1 DST_PORT; hd 2 udp_len_q; hd 3 16'h0000. hd_q advances on ready_i; hd 3 accepted -> DATA.
- DATA: combinational pass-through: valid_o=valid_i, ready_o=ready_i, data_o/len_o/term_o from inputs. Accepted beat adds len_i to cnt_q (reset to 0 on HEAD entry). Accepted term beat -> IDLE; if cnt_q+len_i != udp_len_q-8, len_err_o pulses next cycle.
- pld_len_i = 0 or > 65527: len_err_o pulses the cycle after HEAD entry; datagram still sent with wrapped length.
- cancel_i while not IDLE: cancel_o=1 same cycle, FSM -> IDLE next cycle, no term_o emitted. cancel_i in IDLE ignored, cancel_o=0.
- start_i while in HEAD/DATA ignored (treated as data beat in DATA).

## Timing
- Reset: FSM IDLE; valid_o, ready_o, start_o, term_o, cancel_o, len_err_o, data_o, len_o, udp_len_o all 0.
- start_i at cycle N in IDLE -> header beat 0 on valid_o at N+1; with ready_i held high, first payload beat accepted at N+5.
- Header is registered-state driven; payload path adds zero latency.
- ready_i low stalls header and payload; data_o holds stable while valid_o & ~ready_i.
- cancel_i and term accept in same cycle: cancel wins, no len_err_o.
- nreset low mid-datagram: IDLE next edge, counters cleared.

## Structure
- Package udp_pkg: UDP_HEAD_N=8, UDP_HEAD_BEATS=4, default port constants, header beat index localparams, byte-swap function for MSB-first wire order (shared with rx).
- Sub-module udp_tx_head: header beat mux from hd_q, ports and udp_len_q.

## Test plan
- pld_len=6, ready_i=1, SRC/DST=18070 -> data_o 0x9646,0x9646,0x0E00,0x0000, then 3 payload beats, term on third, len_err_o=0.
- pld_len=5, last beat len_i=1 -> udp length beat 0x0D00, term_o with len_o=1, no error.
- ready_i toggled 1/0 every cycle during header -> each header beat held two cycles, order and start_o only on beat 0 preserved.
- pld_len=6 but app terms after 4 bytes -> len_err_o single pulse cycle after term accept.
- cancel_i asserted at header beat 2 -> cancel_o same cycle, valid_o=0 next cycle, next datagram starts cleanly from beat 0.
- pld_len=65530 -> len_err_o pulse after HEAD entry, length beat carries wrapped 0x0200.
